// File: rtl/byte_lane_packer_pkg.sv
// rtl/byte_lane_packer_pkg.sv - shared constants and lane-map helpers for the byte lane packer
// Contents: LANES/BYTE_W constants, lane_of (destination lane of the m-th byte),
//           map_ok (permutation check of a lane map).
package byte_lane_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    // Destination lane of the m-th byte of a word.
    function automatic logic [3:0] lane_of(input logic [15:0] map, input logic [1:0] m);
        return map[{m, 2'b00} +: 4];
    endfunction

    // True when every nibble names a lane 0..3 and each lane is used exactly once.
    function automatic bit map_ok(input logic [15:0] map);
        logic [3:0] seen;
        seen = 4'h0;
        for (int m = 0; m < LANES; m++) begin
            if (map[4*m +: 4] > 4'd3) begin
                return 1'b0;
            end
            seen[map[4*m +: 2]] = 1'b1;
        end
        return seen == 4'hF;
    endfunction

endpackage

// File: rtl/byte_lane_packer_if.sv
// rtl/byte_lane_packer_if.sv - byte-in / word-out handshake bundle of the byte lane packer
// Signals: in_data/in_valid/in_last/in_ready (byte stream), out_data/out_keep/out_last/
//          out_valid/out_ready (word stream). Modport slave is the packer, master the source/sink.
interface byte_lane_packer_if;
    import byte_lane_pkg::*;

    logic [BYTE_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [LANES*BYTE_W-1:0] out_data;
    logic [LANES-1:0]        out_keep;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );
endinterface

// File: rtl/byte_lane_insert.sv
// rtl/byte_lane_insert.sv - combinational merge of one byte into a lane-mapped accumulator
// Ports: acc_i/keep_i (current accumulator), byte_i, idx_i (byte index in word),
//        acc_o/keep_o (accumulator with byte placed at lane MAP[idx_i]).
module byte_lane_insert
    import byte_lane_pkg::*;
#(
    parameter logic [15:0] MAP = 16'h0123
) (
    input  logic [LANES*BYTE_W-1:0] acc_i,
    input  logic [LANES-1:0]        keep_i,
    input  logic [BYTE_W-1:0]       byte_i,
    input  logic [1:0]              idx_i,
    output logic [LANES*BYTE_W-1:0] acc_o,
    output logic [LANES-1:0]        keep_o
);
    logic [3:0] lane;

    always_comb begin
        lane   = lane_of(MAP, idx_i);
        acc_o  = acc_i;
        keep_o = keep_i;
        acc_o[{lane[1:0], 3'b000} +: BYTE_W] = byte_i;
        keep_o[lane[1:0]]                    = 1'b1;
    end
endmodule

// File: rtl/byte_lane_packer.sv
// rtl/byte_lane_packer.sv - packs a serial byte stream into lane-mapped 32-bit words
// Ports: clk, rst (async, active high), bus (byte_lane_packer_if.slave: byte in, word out),
//        word_count (saturating count of words accepted downstream).
module byte_lane_packer
    import byte_lane_pkg::*;
#(
    parameter logic [15:0] MAP   = 16'h0123,
    parameter logic [7:0]  PAD   = 8'h00,
    parameter int          CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    byte_lane_packer_if.slave     bus,
    output logic [CNT_W-1:0]      word_count
);
    if (!map_ok(MAP)) begin : g_bad_map
        $fatal(1, "FAILED: bad MAP");
    end

    localparam logic [LANES*BYTE_W-1:0] ACC_INIT = {LANES{PAD}};

    logic [1:0]              cnt_q, cnt_d;
    logic [LANES*BYTE_W-1:0] acc_q, acc_d;
    logic [LANES-1:0]        acc_keep_q, acc_keep_d;
    logic [LANES*BYTE_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]        out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;
    logic [CNT_W-1:0]        word_count_q, word_count_d;

    logic [LANES*BYTE_W-1:0] merged_acc;
    logic [LANES-1:0]        merged_keep;
    logic                    out_free;
    logic                    completing;
    logic                    accept;

    // Shared by the accumulate and the completion paths.
    byte_lane_insert #(.MAP(MAP)) u_insert (
        .acc_i  (acc_q),
        .keep_i (acc_keep_q),
        .byte_i (bus.in_data),
        .idx_i  (cnt_q),
        .acc_o  (merged_acc),
        .keep_o (merged_keep)
    );

    always_comb begin
        out_free   = !out_valid_q || bus.out_ready;
        completing = (cnt_q == 2'd3) || bus.in_last;
        // Only a completing byte needs the output register; others always go in.
        bus.in_ready = out_free || !completing;
        accept       = bus.in_valid && bus.in_ready;

        cnt_d        = cnt_q;
        acc_d        = acc_q;
        acc_keep_d   = acc_keep_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d  = 1'b0;
            word_count_d = (word_count_q == {CNT_W{1'b1}}) ? word_count_q : word_count_q + 1'b1;
        end

        if (accept) begin
            if (completing) begin
                // A load in the same cycle as a transfer re-asserts valid.
                out_data_d  = merged_acc;
                out_keep_d  = merged_keep;
                out_last_d  = bus.in_last;
                out_valid_d = 1'b1;
                acc_d       = ACC_INIT;
                acc_keep_d  = '0;
                cnt_d       = 2'd0;
            end else begin
                acc_d      = merged_acc;
                acc_keep_d = merged_keep;
                cnt_d      = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 2'd0;
            acc_q        <= ACC_INIT;
            acc_keep_q   <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            acc_keep_q   <= acc_keep_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
    assign word_count    = word_count_q;
endmodule

// File: tb/tb_byte_lane_packer.sv
// tb/tb_byte_lane_packer.sv - scoreboard bench for byte_lane_packer (default map and reversed map)
module tb_byte_lane_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_lane_packer_if bus_a ();
    byte_lane_packer_if bus_b ();
    logic [15:0] wc_a;
    logic [1:0]  wc_b;

    // Both DUTs see the same byte stream and the same downstream ready.
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_last   = bus_a.in_last;
    assign bus_b.out_ready = bus_a.out_ready;

    byte_lane_packer #(.MAP(16'h0123), .PAD(8'h00), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .word_count(wc_a));
    byte_lane_packer #(.MAP(16'h3210), .PAD(8'h00), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .word_count(wc_b));

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] q_a[$];
    logic [36:0] q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected word per downstream transfer.
    always @(negedge clk) begin
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_a_unexpected: got %h expected none", bus_a.out_data);
            end else begin
                logic [36:0] e;
                e = q_a.pop_front();
                n_cmp++;
                if ({bus_a.out_data, bus_a.out_keep, bus_a.out_last} !== e) begin
                    n_err++;
                    $display("FAIL mon_a_word: got %h/%h/%b expected %h/%h/%b",
                             bus_a.out_data, bus_a.out_keep, bus_a.out_last, e[36:5], e[4:1], e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_b.out_valid && bus_b.out_ready) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_b_unexpected: got %h expected none", bus_b.out_data);
            end else begin
                logic [36:0] e;
                e = q_b.pop_front();
                n_cmp++;
                if ({bus_b.out_data, bus_b.out_keep, bus_b.out_last} !== e) begin
                    n_err++;
                    $display("FAIL mon_b_word: got %h/%h/%b expected %h/%h/%b",
                             bus_b.out_data, bus_b.out_keep, bus_b.out_last, e[36:5], e[4:1], e[0]);
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] da, input logic [31:0] db,
                               input logic [3:0] ka, input logic [3:0] kb, input logic last);
        q_a.push_back({da, ka, last});
        q_b.push_back({db, kb, last});
    endtask

    // Called at posedge+1; returns after the byte has been accepted.
    task automatic send(input logic [7:0] d, input logic last, output int stalls);
        logic rdy;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        bus_a.in_last  = last;
        stalls = 0;
        forever begin
            @(negedge clk);
            rdy = bus_a.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            stalls++;
            if (stalls > 50) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: got stalled expected accept");
                break;
            end
        end
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = 8'h00;
        bus_a.in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d/%0d pending expected 0", name, q_a.size(), q_b.size());
        end
    endtask

    initial begin
        int s;
        int gaps;
        logic [7:0] bytes8 [8];
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = 8'h00;
        bus_a.in_last   = 1'b0;
        bus_a.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, bus_a.out_valid}, 32'h0);
        chk("rst_data", bus_a.out_data, 32'h0);
        chk("rst_keep", {28'b0, bus_a.out_keep}, 32'h0);
        chk("rst_last", {31'b0, bus_a.out_last}, 32'h0);
        chk("rst_wc", {16'b0, wc_a}, 32'h0);
        chk("rst_b_valid", {31'b0, bus_b.out_valid}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b1;

        // Full word, in_last on the 4th byte.
        send(8'h11, 1'b0, s);
        send(8'h22, 1'b0, s);
        send(8'h33, 1'b0, s);
        expect_word(32'h11223344, 32'h44332211, 4'hF, 4'hF, 1'b1);
        send(8'h44, 1'b1, s);
        chk("first_valid_latency", {31'b0, bus_a.out_valid}, 32'h1);
        drain("w1");
        chk("wc_after_1", {16'b0, wc_a}, 32'h1);

        // Eight streaming bytes: two words, no in_ready gap.
        bytes8 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_word(32'h01020304, 32'h04030201, 4'hF, 4'hF, 1'b0);
        expect_word(32'h05060708, 32'h08070605, 4'hF, 4'hF, 1'b1);
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            send(bytes8[i], (i == 7), s);
            gaps += s;
        end
        chk("stream_gaps", gaps, 32'h0);
        drain("stream");

        // Short word of two bytes.
        send(8'hAA, 1'b0, s);
        expect_word(32'hAABB0000, 32'h0000BBAA, 4'hC, 4'h3, 1'b1);
        send(8'hBB, 1'b1, s);
        drain("short2");

        // Single-byte word.
        expect_word(32'h5A000000, 32'h0000005A, 4'h8, 4'h1, 1'b1);
        send(8'h5A, 1'b1, s);
        drain("short1");

        // Back-pressure: held word, three more bytes accepted, fourth stalls.
        bus_a.out_ready = 1'b0;
        expect_word(32'hC1C2C3C4, 32'hC4C3C2C1, 4'hF, 4'hF, 1'b0);
        expect_word(32'hD1D2D3D4, 32'hD4D3D2D1, 4'hF, 4'hF, 1'b1);
        send(8'hC1, 1'b0, s);
        send(8'hC2, 1'b0, s);
        send(8'hC3, 1'b0, s);
        send(8'hC4, 1'b0, s);
        gaps = 0;
        send(8'hD1, 1'b0, s); gaps += s;
        send(8'hD2, 1'b0, s); gaps += s;
        send(8'hD3, 1'b0, s); gaps += s;
        chk("held_accept_gaps", gaps, 32'h0);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'hD4;
        bus_a.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_in_ready", {31'b0, bus_a.in_ready}, 32'h0);
            chk("held_data_stable", bus_a.out_data, 32'hC1C2C3C4);
            @(posedge clk);
            #1;
        end
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'b0, bus_a.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        chk("simul_load_valid", {31'b0, bus_a.out_valid}, 32'h1);
        drain("held");
        chk("wc_a_7", {16'b0, wc_a}, 32'h7);
        chk("wc_b_sat", {30'b0, wc_b}, 32'h3);

        // Asynchronous reset mid-word.
        send(8'h71, 1'b0, s);
        send(8'h72, 1'b0, s);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wc", {16'b0, wc_a}, 32'h0);
        chk("arst_data", bus_a.out_data, 32'h0);
        chk("arst_valid", {31'b0, bus_a.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h01, 1'b0, s);
        send(8'h02, 1'b0, s);
        send(8'h03, 1'b0, s);
        expect_word(32'h01020304, 32'h04030201, 4'hF, 4'hF, 1'b1);
        send(8'h04, 1'b1, s);
        drain("post_rst");
        chk("wc_post_rst", {16'b0, wc_a}, 32'h1);
        chk("wc_b_post_rst", {30'b0, wc_b}, 32'h1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
